axis_systolic_array: RTL and testbench
======================================

# axis_systolic_array

AXI-Stream matrix-multiply engine computing Y(R×C) = X(R×K) · Kw(K×C) on signed integers. Each input beat carries one column of X and the matching row of Kw and is accumulated as an outer product into an R×C array of MAC cells. After the packet's last beat, the finished matrix drains one column per output beat, last column first. The block sits between an AXIS source carrying packed operand beats and an AXIS sink consuming result columns.

## Interface
- R, 2: rows of X and Y; lanes per output beat.
- C, 2: columns of Kw and Y; output beats per matrix.
- WX, 4: signed width of X elements.
- WK, 4: signed width of Kw elements.
- WY, WX+WK+$clog2(K) (K = expected depth, default 2 → 9): signed accumulator and output width.
- LM, 1: multiplier pipeline stages (≥1).
- LA, 1: accumulator stages (≥1). The accumulator register is stage 1; the remaining LA−1 stages delay hand-off.
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  one clock; reset is synchronous and active-high (rstn=1 resets, despite the name).
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&&s_ready.
- s_last  in  1  final beat (k=K−1) of a matrix.
- sx_data  in  R×WX  signed X column k; lane r = X[r][k]; lane 0 at LSBs.
- sk_data  in  C×WK  signed Kw row k; lane c = Kw[k][c]; lane 0 at LSBs. The upstream bus is {sk_data, sx_data}.
- m_valid  out  1  output beat valid.
- m_ready  in  1  output beat consumed when m_valid&&m_ready.
- m_last  out  1  final output beat (column 0).
- m_data  out  R×WY  signed Y column; lane r = Y[r][c].

## Operation
- An accepted beat launches products sx[r]*sk[c] (signed, full precision, sign-extended to WY) through LM stages.
- A product tagged "first" loads acc[r][c]. Any other product adds to it. "First" means the first beat after reset or after an s_last beat.
- Beats with s_valid=0 are bubbles and do not modify accumulators. Any number of beats ≥1 per matrix is legal (K=1 works).
- Accumulation wraps modulo 2^WY. There is no saturation.
- The product carrying s_last, after LA−1 further stages, transfers the whole acc array into the output bank: bank[c][r] = acc[r][c].
- The output bank presents column C−1 first and shifts toward column 0 on each output handshake. m_last=1 only on the column-0 beat.
- The bank is empty after the m_last handshake.
- A stall occurs when the completed matrix reaches hand-off while the bank is still occupied. During a stall, the compute pipeline freezes (clock-enable low) and s_ready=0.
- The stall releases in the cycle the bank empties. The hand-off then occurs at that edge.

## Timing
- During reset and on the first cycle after it: s_ready=0, m_valid=0, m_last=0, m_data=0. All accumulators, pipelines and the bank are cleared, and the "first" flag is set.
- s_ready=1 from the second cycle after reset release, except during stalls.
- s_ready does not depend combinationally on s_valid.
- Latency, bank empty: m_valid rises LM+LA+1 cycles after the edge accepting the s_last beat (3 cycles at LM=LA=1).
- Full throughput: one input beat per cycle. Output drains one beat per cycle when m_ready=1.
- m_data and m_last are held stable while m_valid && !m_ready.
- Simultaneous bank-empty and hand-off in the same cycle: the new matrix loads, and m_valid stays 1 with no bubble.
- Reset mid-packet or mid-drain discards all partial sums and undrained results.

## Structure
- Shared package: default parameters, WY derivation function, packed lane types (x_col_t, k_row_t, y_col_t).
- One natural sub-module: sa_mac_pe. It holds a single signed MAC with an LM-stage multiply, an accumulator with first-flag load, and a freeze input. It is instantiated R×C times.
- The top holds the control pipeline (valid/first/last tags), stall logic and the output bank.

## Test plan
- Beats {sx=(−1,3), sk=(7,6)}, then {sx=(2,−1), sk=(−4,6), last}; m_ready=1 → beat0 m_data=(6,12), m_last=0; beat1 (−15,25), m_last=1; first m_valid 3 cycles after the last input.
- Same matrix, m_ready low for 10 cycles → m_data=(6,12) held stable; no loss after m_ready rises.
- Two back-to-back matrices with m_ready=0 → s_ready drops once the second hits hand-off; both results emerge in order after release.
- Random s_valid gaps (50%) → results identical to the gap-free run.
- Extremes: all X=−8, all Kw=−8, 2 beats → every output equals 128; wrap check with WY reduced to 8 → −128.
- Assert rstn mid-drain, then resend the matrix → no stale beats; correct (6,12), (−15,25).

Source files
------------

// File: rtl/axis_systolic_array_pkg.sv
// Shared definitions for the AXIS systolic matrix-multiply engine.
// Holds the default geometry, the accumulator-width derivation and the packed
// lane types for the default configuration.
package axis_systolic_array_pkg;

  localparam int R_DEF  = 2;
  localparam int C_DEF  = 2;
  localparam int WX_DEF = 4;
  localparam int WK_DEF = 4;
  localparam int K_DEF  = 2;
  localparam int LM_DEF = 1;
  localparam int LA_DEF = 1;

  // Full-precision product plus headroom for summing k products.
  function automatic int wy_calc(input int wx, input int wk, input int k);
    return wx + wk + $clog2(k);
  endfunction

  localparam int WY_DEF = wy_calc(WX_DEF, WK_DEF, K_DEF);

  typedef logic [R_DEF-1:0][WX_DEF-1:0] x_col_t;
  typedef logic [C_DEF-1:0][WK_DEF-1:0] k_row_t;
  typedef logic [R_DEF-1:0][WY_DEF-1:0] y_col_t;

endpackage

// File: rtl/axis_systolic_array_pe.sv
// sa_mac_pe: one signed multiply-accumulate cell.
//   clk, rstn  : clock, synchronous active-high reset
//   freeze     : holds every register (pipeline stall)
//   x, k       : operand lanes, captured every unfrozen cycle
//   acc_en     : product at the last multiply stage is a real beat
//   first      : that product loads the accumulator instead of adding
//   y          : accumulator value delayed by LA-1 stages
module sa_mac_pe
  import axis_systolic_array_pkg::*;
#(
  parameter int WX = WX_DEF,
  parameter int WK = WK_DEF,
  parameter int WY = WY_DEF,
  parameter int LM = LM_DEF,
  parameter int LA = LA_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 freeze,
  input  logic signed [WX-1:0] x,
  input  logic signed [WK-1:0] k,
  input  logic                 acc_en,
  input  logic                 first,
  output logic signed [WY-1:0] y
);

  logic signed [WX-1:0]    xq;
  logic signed [WK-1:0]    kq;
  logic signed [WX+WK-1:0] p_full;
  logic signed [WY-1:0]    prod [LM];
  // dly[0] is the accumulator; later entries snapshot it so the next
  // matrix may start accumulating before hand-off.
  logic signed [WY-1:0]    dly  [LA];

  assign p_full = xq * kq;
  assign y      = dly[LA-1];

  always_ff @(posedge clk) begin
    if (rstn) begin
      xq <= '0;
      kq <= '0;
      for (int i = 0; i < LM; i++) prod[i] <= '0;
      for (int i = 0; i < LA; i++) dly[i]  <= '0;
    end else if (!freeze) begin
      xq      <= x;
      kq      <= k;
      prod[0] <= WY'(p_full);
      for (int i = 1; i < LM; i++) prod[i] <= prod[i-1];
      if (acc_en) dly[0] <= first ? prod[LM-1] : dly[0] + prod[LM-1];
      for (int i = 1; i < LA; i++) dly[i] <= dly[i-1];
    end
  end

endmodule

// File: rtl/axis_systolic_array.sv
// axis_systolic_array: Y(RxC) = X(RxK) * Kw(KxC) over AXI-Stream.
//   clk, rstn         : clock, synchronous active-high reset
//   s_valid/s_ready   : input beat handshake, s_last marks the final k
//   sx_data           : X column k, lane r = X[r][k]
//   sk_data           : Kw row k, lane c = Kw[k][c]
//   m_valid/m_ready   : output beat handshake, m_last on column 0
//   m_data            : one Y column, last column first
module axis_systolic_array
  import axis_systolic_array_pkg::*;
#(
  parameter int R  = R_DEF,
  parameter int C  = C_DEF,
  parameter int WX = WX_DEF,
  parameter int WK = WK_DEF,
  parameter int K  = K_DEF,
  parameter int WY = wy_calc(WX, WK, K),
  parameter int LM = LM_DEF,
  parameter int LA = LA_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  input  logic [R-1:0][WX-1:0]   sx_data,
  input  logic [C-1:0][WK-1:0]   sk_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [R-1:0][WY-1:0]   m_data
);

  // Stage 0 = operand capture, 1..LM = multiply, LM+1..LM+LA = accumulate.
  localparam int STAGES = LM + LA;
  localparam int CNT_W  = $clog2(C + 1);

  logic [STAGES:0]           vld_pipe;
  logic [STAGES:0]           last_pipe;
  logic [LM:0]               first_pipe;
  logic                      first_q;
  logic                      ready_q;
  logic [C-1:0][R-1:0][WY-1:0] bank;
  logic [CNT_W-1:0]          cnt;
  logic [R-1:0][C-1:0][WY-1:0] acc_y;
  logic                      accept, handoff_req, emptying, stall, load;

  assign m_valid     = (cnt != '0);
  assign m_last      = (cnt == CNT_W'(1));
  assign m_data      = bank[C-1];
  assign emptying    = m_valid && m_ready && m_last;
  assign handoff_req = vld_pipe[STAGES] && last_pipe[STAGES];
  // Bank still holds an undrained matrix: freeze everything upstream.
  assign stall       = handoff_req && m_valid && !emptying;
  assign load        = handoff_req && !stall;
  assign s_ready     = ready_q && !stall;
  assign accept      = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rstn) begin
      ready_q    <= 1'b0;
      first_q    <= 1'b1;
      vld_pipe   <= '0;
      last_pipe  <= '0;
      first_pipe <= '0;
    end else begin
      ready_q <= 1'b1;
      if (accept) first_q <= s_last;
      if (!stall) begin
        vld_pipe   <= {vld_pipe[STAGES-1:0], accept};
        last_pipe  <= {last_pipe[STAGES-1:0], s_last};
        first_pipe <= {first_pipe[LM-1:0], first_q};
      end
    end
  end

  // Output bank: transpose on load, shift toward column C-1 on each beat.
  // A load in the same cycle as the final beat wins, so no bubble appears.
  always_ff @(posedge clk) begin
    if (rstn) begin
      bank <= '0;
      cnt  <= '0;
    end else if (load) begin
      for (int c = 0; c < C; c++)
        for (int r = 0; r < R; r++)
          bank[c][r] <= acc_y[r][c];
      cnt <= CNT_W'(C);
    end else if (m_valid && m_ready) begin
      for (int c = C - 1; c > 0; c--) bank[c] <= bank[c-1];
      bank[0] <= '0;
      cnt     <= cnt - CNT_W'(1);
    end
  end

  for (genvar gr = 0; gr < R; gr++) begin : g_row
    for (genvar gc = 0; gc < C; gc++) begin : g_col
      sa_mac_pe #(.WX(WX), .WK(WK), .WY(WY), .LM(LM), .LA(LA)) u_pe (
        .clk    (clk),
        .rstn   (rstn),
        .freeze (stall),
        .x      (sx_data[gr]),
        .k      (sk_data[gc]),
        .acc_en (vld_pipe[LM]),
        .first  (first_pipe[LM]),
        .y      (acc_y[gr][gc])
      );
    end
  end

endmodule

// File: tb/tb_axis_systolic_array.sv
// Directed bench for axis_systolic_array (R=C=2, WX=WK=4, WY=9) with a second
// instance at WY=8 to observe accumulator wrap. Inputs are shared.
module tb_axis_systolic_array;

  logic             clk = 1'b0;
  logic             rstn;
  logic             s_valid, s_last, m_ready;
  logic [1:0][3:0]  sx_data, sk_data;
  logic             s_ready, m_valid, m_last;
  logic [1:0][8:0]  m_data;
  logic             s_ready8, m_valid8, m_last8;
  logic [1:0][7:0]  m_data8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axis_systolic_array dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .sx_data(sx_data), .sk_data(sk_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_data(m_data)
  );

  axis_systolic_array #(.WY(8)) dut8 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready8),
    .s_last(s_last), .sx_data(sx_data), .sk_data(sk_data),
    .m_valid(m_valid8), .m_ready(m_ready), .m_last(m_last8), .m_data(m_data8)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle for 'gap' cycles with poison data, then present one beat until taken.
  task automatic send(input string tag, input int x0, input int x1,
                      input int k0, input int k1, input bit last, input int gap);
    logic took;
    int   x0v, x1v, k0v, k1v;
    x0v = x0; x1v = x1; k0v = k0; k1v = k1;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0; s_last = 1'b1;
      sx_data = 8'h77; sk_data = 8'h77;
      tick();
    end
    s_valid    = 1'b1;
    s_last     = last;
    sx_data[0] = x0v[3:0]; sx_data[1] = x1v[3:0];
    sk_data[0] = k0v[3:0]; sk_data[1] = k1v[3:0];
    took = 1'b0;
    for (int n = 0; n < 50 && !took; n++) begin
      took = s_ready;
      tick();
    end
    chk({tag, "_accept"}, took, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Wait for an output beat with m_ready high, check it, consume it.
  task automatic recv(input string tag, input int e0, input int e1,
                      input bit elast, input bit chk8, input int e8,
                      output int waited);
    m_ready = 1'b1;
    waited  = 0;
    while (!m_valid && waited < 50) begin
      tick();
      waited++;
    end
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_d0"}, $signed(m_data[0]), e0);
    chk({tag, "_d1"}, $signed(m_data[1]), e1);
    chk({tag, "_last"}, m_last, elast);
    if (chk8) begin
      chk({tag, "_w8_valid"}, m_valid8, 1);
      chk({tag, "_w8_last"}, m_last8, elast);
      chk({tag, "_w8_d0"}, $signed(m_data8[0]), e8);
      chk({tag, "_w8_d1"}, $signed(m_data8[1]), e8);
    end
    tick();
  endtask

  // Reference matrix: X=[[-1,2],[3,-1]], Kw=[[7,6],[-4,6]] -> Y=[[-15,6],[25,12]]
  task automatic send_ref(input string tag);
    send({tag, "_b0"}, -1, 3, 7, 6, 1'b0, 0);
    send({tag, "_b1"}, 2, -1, -4, 6, 1'b1, 0);
  endtask

  initial begin
    int w;
    rstn = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    sx_data = '0; sk_data = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    rstn = 1'b0;
    chk("post_rst_s_ready", s_ready, 0);
    tick();
    chk("ready_after_rst", s_ready, 1);

    // Basic matrix, latency and drain order
    m_ready = 1'b1;
    send_ref("t1");
    recv("t1_c1", 6, 12, 1'b0, 1'b0, 0, w);
    chk("t1_latency", w, 3);
    recv("t1_c0", -15, 25, 1'b1, 1'b0, 0, w);
    chk("t1_empty", m_valid, 0);

    // Backpressure: output held stable
    m_ready = 1'b0;
    send_ref("t2");
    repeat (5) tick();
    chk("t2_hold_valid", m_valid, 1);
    chk("t2_hold_d0a", $signed(m_data[0]), 6);
    repeat (5) tick();
    chk("t2_hold_d0b", $signed(m_data[0]), 6);
    chk("t2_hold_d1b", $signed(m_data[1]), 12);
    chk("t2_hold_last", m_last, 0);
    recv("t2_c1", 6, 12, 1'b0, 1'b0, 0, w);
    recv("t2_c0", -15, 25, 1'b1, 1'b0, 0, w);

    // Back-to-back matrices into a full bank: stall then ordered release.
    // Second: X=[[1,1],[1,1]], Kw=[[1,2],[3,4]] -> every row (4,6)
    m_ready = 1'b0;
    send_ref("t3a");
    send("t3b_b0", 1, 1, 1, 2, 1'b0, 0);
    send("t3b_b1", 1, 1, 3, 4, 1'b1, 0);
    repeat (5) tick();
    chk("t3_stall_s_ready", s_ready, 0);
    chk("t3_stall_d0", $signed(m_data[0]), 6);
    recv("t3a_c1", 6, 12, 1'b0, 1'b0, 0, w);
    recv("t3a_c0", -15, 25, 1'b1, 1'b0, 0, w);
    recv("t3b_c1", 6, 6, 1'b0, 1'b0, 0, w);
    chk("t3_no_bubble", w, 0);
    recv("t3b_c0", 4, 4, 1'b1, 1'b0, 0, w);
    chk("t3_ready_back", s_ready, 1);

    // Gaps with poisoned bubbles, K=3:
    // X=[[1,-2,4],[2,0,-3]], Kw=[[3,-1],[1,1],[-2,2]] -> Y=[[-7,5],[12,-8]]
    m_ready = 1'b1;
    send("t4_b0", 1, 2, 3, -1, 1'b0, int'($urandom_range(0, 1)));
    send("t4_b1", -2, 0, 1, 1, 1'b0, 2);
    send("t4_b2", 4, -3, -2, 2, 1'b1, int'($urandom_range(0, 1)));
    recv("t4_c1", 5, -8, 1'b0, 1'b0, 0, w);
    recv("t4_c0", -7, 12, 1'b1, 1'b0, 0, w);
    // Reference matrix again with random gaps
    send("t4r_b0", -1, 3, 7, 6, 1'b0, int'($urandom_range(0, 2)));
    send("t4r_b1", 2, -1, -4, 6, 1'b1, int'($urandom_range(0, 2)));
    recv("t4r_c1", 6, 12, 1'b0, 1'b0, 0, w);
    recv("t4r_c0", -15, 25, 1'b1, 1'b0, 0, w);

    // K=1: X=[[3],[-2]], Kw=[[-5,4]] -> Y=[[-15,12],[10,-8]]
    send("t5_b0", 3, -2, -5, 4, 1'b1, 0);
    recv("t5_c1", 12, -8, 1'b0, 1'b0, 0, w);
    recv("t5_c0", -15, 10, 1'b1, 1'b0, 0, w);

    // Extremes: 2 * (-8 * -8) = 128, wraps to -128 at WY=8
    send("t6_b0", -8, -8, -8, -8, 1'b0, 0);
    send("t6_b1", -8, -8, -8, -8, 1'b1, 0);
    chk("t6_w8_s_ready", s_ready8, s_ready);
    recv("t6_c1", 128, 128, 1'b0, 1'b1, -128, w);
    recv("t6_c0", 128, 128, 1'b1, 1'b1, -128, w);

    // Reset mid-drain and mid-packet
    m_ready = 1'b0;
    send_ref("t7");
    recv("t7_c1", 6, 12, 1'b0, 1'b0, 0, w);
    m_ready = 1'b0;
    rstn = 1'b1;
    tick();
    chk("t7_rst_m_valid", m_valid, 0);
    chk("t7_rst_m_data", m_data, 0);
    chk("t7_rst_m_last", m_last, 0);
    rstn = 1'b0;
    chk("t7_post_rst_s_ready", s_ready, 0);
    tick();
    send("t7_partial", 7, 7, 7, 7, 1'b0, 0);
    tick();
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    tick();
    chk("t7_no_stale", m_valid, 0);
    send_ref("t7r");
    recv("t7r_c1", 6, 12, 1'b0, 1'b0, 0, w);
    recv("t7r_c0", -15, 25, 1'b1, 1'b0, 0, w);
    chk("t7_empty", m_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
